// File: rtl/hyperbus_txn_if.sv
// Host-side request/data and ioddr-side signals of the HyperBus transaction sequencer.
// The slave modport is the sequencer; master is whoever drives requests and models the PHY.
interface hyperbus_txn_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [7:0]  req_len_i;
  logic [15:0] wdat_i;
  logic        wdat_valid_i;
  logic        wdat_ready_o;
  logic [15:0] rdat_o;
  logic        rdat_valid_o;
  logic        done_o;
  logic        underrun_o;
  logic        cs_n_o;
  logic        ck_en_o;
  logic        ddr_oe_o;
  logic [15:0] ddr_dat_o;
  logic [15:0] ddr_dat_i;
  logic        rwds_oe_o;
  logic [1:0]  rwds_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_len_i, wdat_i, wdat_valid_i, ddr_dat_i,
    output req_ready_o, wdat_ready_o, rdat_o, rdat_valid_o, done_o, underrun_o,
           cs_n_o, ck_en_o, ddr_oe_o, ddr_dat_o, rwds_oe_o, rwds_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_len_i, wdat_i, wdat_valid_i, ddr_dat_i,
    input  req_ready_o, wdat_ready_o, rdat_o, rdat_valid_o, done_o, underrun_o,
           cs_n_o, ck_en_o, ddr_oe_o, ddr_dat_o, rwds_oe_o, rwds_o
  );
endinterface

// File: rtl/hyperbus_txn_fsm.sv
// HyperBus burst sequencer: CS#/CK control, 48-bit CA phase, fixed latency, DDR data phase.
// Every output is a flop whose next value is derived from the next state.
module hyperbus_txn_fsm #(
  parameter int unsigned LAT_CYCLES = 12,
  parameter int unsigned RD_DELAY   = 2
) (
  input logic         clk_i,
  input logic         rst_i,
  hyperbus_txn_if.slave bus_io
);

  typedef enum logic [3:0] {
    StIdle, StCss, StCa0, StCa1, StCa2, StLat, StData, StDrain, StCsh
  } state_e;

  state_e              state_q, state_d;
  logic [8:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic                req_ready_q, req_ready_d;
  logic                wdat_ready_q, wdat_ready_d;
  logic [15:0]         rdat_q, rdat_d;
  logic                done_q, done_d;
  logic                underrun_q, underrun_d;
  logic                cs_n_q, cs_n_d;
  logic                ck_en_q, ck_en_d;
  logic                ddr_oe_q, ddr_oe_d;
  logic [15:0]         ddr_dat_q, ddr_dat_d;
  logic                rwds_oe_q, rwds_oe_d;
  logic [1:0]          rwds_q, rwds_d;
  logic [RD_DELAY-1:0] rd_pipe_q, rd_pipe_d, rd_in;
  logic [47:0]         ca;
  logic                data_wr;

  assign ca = {~we_q, 1'b0, 1'b1, addr_q[31:3], 13'd0, addr_q[2:0]};

  // The high byte of each CA word goes out on the first (rising) edge, i.e. in bits [7:0].
  function automatic logic [15:0] first_edge_hi(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    len_d      = len_q;
    underrun_d = underrun_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.req_valid_i && req_ready_q) begin
          state_d    = StCss;
          we_d       = bus_io.req_we_i;
          addr_d     = bus_io.req_addr_i;
          len_d      = bus_io.req_len_i;
          underrun_d = 1'b0;
        end
      end
      StCss: state_d = StCa0;
      StCa0: state_d = StCa1;
      StCa1: state_d = StCa2;
      StCa2: begin
        state_d = StLat;
        cnt_d   = 9'(LAT_CYCLES - 1);
      end
      StLat: begin
        if (cnt_q == 9'd0) begin
          state_d = StData;
          cnt_d   = {1'b0, len_q};
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      StData: begin
        if (cnt_q == 9'd0) begin
          if (we_q) begin
            state_d = StCsh;
          end else begin
            state_d = StDrain;
            cnt_d   = 9'(RD_DELAY - 1);
          end
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      StDrain: begin
        if (cnt_q == 9'd0) state_d = StCsh;
        else               cnt_d   = cnt_q - 9'd1;
      end
      StCsh:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A write DATA clk consumes the word offered while wdat_ready_o was high, present or not.
    data_wr = (state_d == StData) && we_q;
    if (data_wr && !bus_io.wdat_valid_i) underrun_d = 1'b1;

    req_ready_d  = (state_d == StIdle);
    // CS# stays low through CSH for hold time and rises on the return to IDLE.
    cs_n_d       = (state_d == StIdle);
    ck_en_d      = (state_d inside {StCa0, StCa1, StCa2, StLat, StData});
    ddr_oe_d     = (state_d inside {StCa0, StCa1, StCa2}) || data_wr;
    rwds_oe_d    = data_wr;
    rwds_d       = (data_wr && !bus_io.wdat_valid_i) ? 2'b11 : 2'b00;
    done_d       = (state_d == StCsh);
    wdat_ready_d = we_q && (((state_d == StLat) && (cnt_d == 9'd0)) ||
                            ((state_d == StData) && (cnt_d != 9'd0)));

    unique case (state_d)
      StCa0:   ddr_dat_d = first_edge_hi(ca[47:32]);
      StCa1:   ddr_dat_d = first_edge_hi(ca[31:16]);
      StCa2:   ddr_dat_d = first_edge_hi(ca[15:0]);
      StData:  ddr_dat_d = (data_wr && bus_io.wdat_valid_i) ? bus_io.wdat_i : 16'h0000;
      default: ddr_dat_d = 16'h0000;
    endcase

    // Bit j marks a read DATA clk j+1 clks ago; the top bit lines up with the PHY latency.
    rd_in     = '0;
    rd_in[0]  = (state_q == StData) && !we_q;
    rd_pipe_d = (rd_pipe_q << 1) | rd_in;
    rdat_d    = rd_pipe_d[RD_DELAY-1] ? bus_io.ddr_dat_i : rdat_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      req_ready_q  <= 1'b0;
      wdat_ready_q <= 1'b0;
      rdat_q       <= '0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
      cs_n_q       <= 1'b1;
      ck_en_q      <= 1'b0;
      ddr_oe_q     <= 1'b0;
      ddr_dat_q    <= '0;
      rwds_oe_q    <= 1'b0;
      rwds_q       <= '0;
      rd_pipe_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      req_ready_q  <= req_ready_d;
      wdat_ready_q <= wdat_ready_d;
      rdat_q       <= rdat_d;
      done_q       <= done_d;
      underrun_q   <= underrun_d;
      cs_n_q       <= cs_n_d;
      ck_en_q      <= ck_en_d;
      ddr_oe_q     <= ddr_oe_d;
      ddr_dat_q    <= ddr_dat_d;
      rwds_oe_q    <= rwds_oe_d;
      rwds_q       <= rwds_d;
      rd_pipe_q    <= rd_pipe_d;
    end
  end

  assign bus_io.req_ready_o  = req_ready_q;
  assign bus_io.wdat_ready_o = wdat_ready_q;
  assign bus_io.rdat_o       = rdat_q;
  assign bus_io.rdat_valid_o = rd_pipe_q[RD_DELAY-1];
  assign bus_io.done_o       = done_q;
  assign bus_io.underrun_o   = underrun_q;
  assign bus_io.cs_n_o       = cs_n_q;
  assign bus_io.ck_en_o      = ck_en_q;
  assign bus_io.ddr_oe_o     = ddr_oe_q;
  assign bus_io.ddr_dat_o    = ddr_dat_q;
  assign bus_io.rwds_oe_o    = rwds_oe_q;
  assign bus_io.rwds_o       = rwds_q;

endmodule
